// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and arbitration helper for the LC-3 fetch/memaccess memory arbiter.
package lc3_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } arb_src_t;

  localparam int unsigned STARVE_LIMIT = 2;

  // dm wins by default; fetch wins once it has lost STARVE_LIMIT times in a row
  function automatic arb_src_t pick_src(input logic if_req, input logic dm_req,
                                        input logic [1:0] starve_cnt);
    if (if_req && (!dm_req || starve_cnt == 2'(STARVE_LIMIT))) return SRC_IF;
    return SRC_DM;
  endfunction

endpackage

// File: rtl/lc3_mem_arb_timer.sv
// Access wait counter; expired goes high once MAX_WAIT stalled cycles have elapsed.
module lc3_mem_arb_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating count; clear has priority over tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (tick && cnt != CNT_W'(MAX_WAIT)) begin
      cnt     <= cnt + CNT_W'(1);
      expired <= (cnt + CNT_W'(1)) == CNT_W'(MAX_WAIT);
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-requester (fetch / memaccess) arbiter for a shared single-port LC-3 memory.
// Optional access timeout enabled by defining LC3_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("lc3_mem_arbiter: MAX_WAIT must be at least 1");
  end

  arb_state_t state;
  logic [1:0] starve_cnt;
  logic       arb_en;
  arb_src_t   win_c;
  logic       acc_done_c;

  assign win_c = pick_src(if_req, dm_req, starve_cnt);

`ifdef LC3_ARB_TIMEOUT_EN
  logic expired;
  logic timer_clear_c;
  logic timer_tick_c;

  assign timer_clear_c = (state == IDLE);
  assign timer_tick_c  = (state != IDLE) && !mem_ready;
  assign acc_done_c    = mem_ready || expired;

  lc3_mem_arb_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear_c),
    .tick   (timer_tick_c),
    .expired(expired)
  );
`else
  assign acc_done_c  = mem_ready;
  assign timeout_err = 1'b0;
`endif

  // arb_en holds off arbitration for one edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 2'd0;
      arb_en     <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      arb_en    <= 1'b1;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_en && (if_req || dm_req)) begin
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (win_c == SRC_IF) begin
              state      <= ACC_IF;
              if_gnt     <= 1'b1;
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              mem_wdata  <= '0;
              starve_cnt <= 2'd0;
            end else begin
              state     <= ACC_DM;
              dm_gnt    <= 1'b1;
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
              if (if_req && starve_cnt != 2'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 2'd1;
            end
          end
        end
        ACC_IF, ACC_DM: begin
          // A timed-out access completes with zero data
          if (acc_done_c) begin
            state  <= IDLE;
            busy   <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
            timeout_err <= !mem_ready;
`endif
            if (state == ACC_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter (default build and LC3_ARB_TIMEOUT_EN build).
module tb_lc3_mem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  lc3_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

    // Reset state
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
    check("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // Single fetch
    if_req  = 1'b1;
    if_addr = 16'h3000;
    step();
    check("if_gnt", 32'(if_gnt), 32'd1);
    check("if_mem_addr", 32'(mem_addr), 32'h3000);
    check("if_mem_en_we", 32'({mem_en, mem_we}), 32'b10);
    check("if_busy", 32'(busy), 32'd1);
    if_req    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    step();
    check("if_gnt_pulse", 32'(if_gnt), 32'd0);
    check("if_rvalid", 32'(if_rvalid), 32'd1);
    check("if_rdata", 32'(if_rdata), 32'h1234);
    check("if_done_idle", 32'({busy, mem_en}), 32'd0);
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    step();
    check("if_rvalid_pulse", 32'(if_rvalid), 32'd0);
    check("if_rdata_hold", 32'(if_rdata), 32'h1234);

    // memaccess write with one stall cycle
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 16'h4000;
    dm_wdata = 16'hBEEF;
    step();
    check("dm_gnt", 32'(dm_gnt), 32'd1);
    check("dm_mem_we", 32'({mem_en, mem_we}), 32'b11);
    check("dm_mem_addr", 32'(mem_addr), 32'h4000);
    check("dm_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    step();
    check("dm_stall", 32'({dm_gnt, busy, mem_we, dm_rvalid}), 32'b0110);
    mem_ready = 1'b1;
    mem_rdata = 16'h5555;
    step();
    check("dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("dm_rdata", 32'(dm_rdata), 32'h5555);
    check("dm_we_drop", 32'(mem_we), 32'd0);
    mem_ready = 1'b0;
    step();

    // Both requesting continuously: dm, dm, if, ...
    if_req    = 1'b1;
    if_addr   = 16'h3100;
    dm_req    = 1'b1;
    dm_addr   = 16'h4100;
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("arb_gnt%0d", i), 32'({dm_gnt, if_gnt}), 32'(exp_gnt[i]));
      step();
      check($sformatf("arb_rvalid%0d", i), 32'({dm_rvalid, if_rvalid, busy}),
            32'({exp_gnt[i], 1'b0}));
    end
    if_req    = 1'b0;
    dm_req    = 1'b0;
    mem_ready = 1'b1;

    // mem_ready while idle is ignored
    step();
    check("idle_ready_rv0", 32'({if_rvalid, dm_rvalid, busy}), 32'd0);
    step();
    check("idle_ready_rv1", 32'({if_rvalid, dm_rvalid, busy}), 32'd0);
    mem_ready = 1'b0;

    // Fetch with mem_ready never arriving
    if_req  = 1'b1;
    if_addr = 16'h7000;
    step();
    check("to_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to_wait%0d", i), 32'({busy, timeout_err}), 32'b10);
    end
    step();
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_rvalid", 32'(if_rvalid), 32'd1);
    check("to_rdata", 32'(if_rdata), 32'd0);
    check("to_idle", 32'(busy), 32'd0);
    step();
    check("to_err_pulse", 32'(timeout_err), 32'd0);
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (busy !== 1'b1 || timeout_err !== 1'b0 || if_rvalid !== 1'b0) bad++;
      end
      check("hold_busy_100", 32'(bad), 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = 16'h2222;
    step();
    check("hold_rvalid", 32'(if_rvalid), 32'd1);
    check("hold_rdata", 32'(if_rdata), 32'h2222);
    mem_ready = 1'b0;
`endif
    step();

    // Reset two cycles into a memaccess read
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h5000;
    step();
    check("mr_gnt", 32'(dm_gnt), 32'd1);
    dm_req = 1'b0;
    step();
    #1 reset_n = 1'b0;
    #1;
    check("mr_busy", 32'({busy, mem_en}), 32'd0);
    check("mr_mem_addr", 32'(mem_addr), 32'd0);
    check("mr_dm_rdata", 32'(dm_rdata), 32'd0);
    mem_ready = 1'b1;
    step();
    check("mr_no_rvalid", 32'(dm_rvalid), 32'd0);
    step();
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 16'h6000;
    dm_wdata  = 16'hCAFE;
    step();
    check("mr_arm_gap", 32'({dm_gnt, busy}), 32'd0);
    step();
    check("mr_regnt", 32'(dm_gnt), 32'd1);
    check("mr_readdr", 32'(mem_addr), 32'h6000);
    check("mr_rewdata", 32'(mem_wdata), 32'hCAFE);
    dm_req    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hA5A5;
    step();
    check("mr_rvalid", 32'(dm_rvalid), 32'd1);
    check("mr_rdata", 32'(dm_rdata), 32'hA5A5);
    mem_ready = 1'b0;
    step();
    check("mr_rvalid_pulse", 32'(dm_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width of all ports.
REQ-002 Parameter DATA_W, 16, data width of all ports.
REQ-003 Parameter MAX_WAIT, 15, the highest number of cycles the block waits for mem_ready before timeout.
REQ-004 Port clock  in  1  the single clock; all state updates on the rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Port if_req  in  1 / if_addr  in  ADDR_W  fetch read request and address.
REQ-007 Port if_gnt  out  1 / if_rvalid  out  1 / if_rdata  out  DATA_W  fetch grant pulse, completion pulse and read data.
REQ-008 Port dm_req  in  1 / dm_we  in  1 / dm_addr  in  ADDR_W / dm_wdata  in  DATA_W  memaccess request.
REQ-009 Port dm_gnt  out  1 / dm_rvalid  out  1 / dm_rdata  out  DATA_W  memaccess grant pulse, completion pulse and read data.
REQ-010 Port mem_en, mem_we  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  DATA_W  shared single-port memory command.
REQ-011 Port mem_rdata  in  DATA_W / mem_ready  in  1  memory read data and access-complete strobe.
REQ-012 Port busy  out  1 / timeout_err  out  1  access in flight, and a one-cycle timeout pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACC_IF and ACC_DM.
- IDLE: on a sampled request, go to ACC_IF or ACC_DM and capture that requester's address, we and wdata.
REQ-014 Arbitration SHALL favour dm over if by default.
- When both request and starve_cnt==2, if SHALL win instead.
- starve_cnt (2 bits) counts dm grants made while if_req was also high.
- It SHALL clear on every if grant and saturate at 2.
REQ-015 In the first cycle of ACC_x, x_gnt SHALL pulse for exactly one cycle.
REQ-016 Throughout ACC_x, mem_en=1 and mem_addr/mem_we/mem_wdata SHALL equal the captured values; mem_we SHALL be 0 in ACC_IF.
REQ-017 When mem_ready=1 is sampled in ACC_x:
- x_rvalid SHALL pulse in the next cycle, with x_rdata = mem_rdata registered at that edge (reads and writes alike).
- The FSM SHALL return to IDLE, so the minimum access is 3 cycles from request to rvalid.
REQ-018 x_rdata SHALL hold its last value until the next completion to that requester.
REQ-019 Requesters SHALL hold req and request fields stable until gnt; req sampled during the other requester's access SHALL wait; no request SHALL be lost.
REQ-020 mem_ready sampled in IDLE SHALL be ignored.
REQ-021 busy SHALL be 1 exactly while the state is not IDLE.
REQ-022 A new request SHALL be accepted in the cycle rvalid is high, because the FSM is already in IDLE.

Reset
REQ-023 Assertion of reset_n=0 SHALL immediately force the following, even mid-access:
- state=IDLE and starve_cnt=0;
- all gnt/rvalid/mem_en/mem_we/busy/timeout_err=0;
- mem_addr, mem_wdata, if_rdata and dm_rdata=0.
REQ-024 An access in progress at reset SHALL be dropped with no rvalid; the first arbitration after deassertion SHALL happen at the second rising edge.

Configuration
REQ-025 Macro LC3_ARB_TIMEOUT_EN present:
- A wait counter SHALL clear on ACC entry and increment each ACC cycle without mem_ready.
- If it reaches MAX_WAIT, then next cycle: timeout_err=1, x_rvalid=1, x_rdata=0, state=IDLE.
REQ-026 Macro LC3_ARB_TIMEOUT_EN absent: ACC SHALL wait indefinitely for mem_ready, timeout_err SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-027 Package lc3_mem_arb_pkg SHALL hold:
- the state enum arb_state_t {IDLE, ACC_IF, ACC_DM};
- the requester enum arb_src_t {SRC_IF, SRC_DM};
- the constant STARVE_LIMIT=2.
REQ-028 The timeout counter SHALL be sub-module lc3_mem_arb_timer (inputs clear, tick; output expired), instantiated only under LC3_ARB_TIMEOUT_EN.

Verification
REQ-029 A single fetch with if_addr=16'h3000 and mem_ready one cycle after gnt SHALL give if_gnt, then mem_addr=16'h3000 with mem_we=0, then if_rvalid with if_rdata = mem_rdata = 16'h1234.
REQ-030 A dm write (addr 16'h4000, wdata 16'hBEEF) with if_req idle SHALL put mem_we=1, mem_wdata=16'hBEEF on the bus, then pulse dm_rvalid.
REQ-031 With if_req and dm_req both held high continuously, the grant order SHALL be dm, dm, if, dm, dm, if.
REQ-032 reset_n=0 asserted two cycles into an ACC_DM access SHALL immediately clear busy and mem_en, give no dm_rvalid, and let the next request be serviced normally.
REQ-033 With LC3_ARB_TIMEOUT_EN, MAX_WAIT=4 and mem_ready held 0, the bench SHALL see timeout_err and if_rvalid with if_rdata=0, then IDLE; without the macro, busy SHALL stay 1 for 100 cycles.
REQ-034 A mem_ready pulse while IDLE SHALL produce no rvalid.
